// File: rtl/rf_read_sequencer_pkg.sv
// Shared definitions for the register-file read sequencer.
// Holds the sequencer FSM state encoding and the hard-wired zero register index.
package rf_read_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        CAP_B = 3'd3,
        HOLD  = 3'd4
    } seq_state_e;

    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/rf_read_sequencer_if.sv
// Bus bundle between the read sequencer and its environment.
//   request side : req_valid/req_ready handshake with req_rs1/req_rs2
//   register file: rf_rdaddress out, rf_q back one cycle later
//   write snoop  : wr_en/wr_addr/wr_data copy of the register-file write port
//   operand side : op_valid/op_ready handshake with op_a/op_b, plus busy
// master = environment (requester, register file, consumer); slave = sequencer.
interface rf_read_sequencer_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_rs1;
    logic [ADDR_WIDTH-1:0] req_rs2;
    logic [ADDR_WIDTH-1:0] rf_rdaddress;
    logic [DATA_WIDTH-1:0] rf_q;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  busy;

    modport master (
        output req_valid, req_rs1, req_rs2, rf_q, wr_en, wr_addr, wr_data, op_ready,
        input  req_ready, rf_rdaddress, op_valid, op_a, op_b, busy
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, rf_q, wr_en, wr_addr, wr_data, op_ready,
        output req_ready, rf_rdaddress, op_valid, op_a, op_b, busy
    );
endinterface

// File: rtl/rf_operand_fwd.sv
// Per-operand forwarding select.
//   addr      : latched register index of this operand
//   base      : value used when nothing newer is known (rf_q or the held operand)
//   wr_*      : snooped register-file write this cycle
//   fwd_valid/fwd_data : newest write seen earlier in the fetch window
//   hit       : this cycle's write targets this operand
//   value     : operand value to capture; register 0 always reads as zero
module rf_operand_fwd
    import rf_read_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  fwd_valid,
    input  logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] value
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    // Priority: zero register, then this cycle's write, then an earlier write, then base.
    always_comb begin
        hit   = 1'b0;
        value = base;
        if (addr == ZERO_ADDR) begin
            value = {DATA_WIDTH{1'b0}};
        end else if (wr_en && (wr_addr != ZERO_ADDR) && (wr_addr == addr)) begin
            hit   = 1'b1;
            value = wr_data;
        end else if (fwd_valid) begin
            value = fwd_data;
        end else begin
            value = base;
        end
    end

endmodule

// File: rtl/rf_read_sequencer.sv
// Operand-fetch sequencer: accepts (rs1, rs2), reads both through a single
// synchronous register-file read port, forwards writes that race the reads,
// and presents op_a/op_b until the consumer takes them.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : rf_read_sequencer_if slave (request, RF read, write snoop, operands)
module rf_read_sequencer
    import rf_read_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    rf_read_sequencer_if.slave bus
);

    seq_state_e            state_r;
    seq_state_e            state_next_s;
    logic                  accept_s;
    logic                  window_s;
    logic [ADDR_WIDTH-1:0] rs1_r;
    logic [ADDR_WIDTH-1:0] rs2_r;
    logic [ADDR_WIDTH-1:0] rdaddress_s;
    logic [DATA_WIDTH-1:0] op_a_r;
    logic [DATA_WIDTH-1:0] op_b_r;
    logic [DATA_WIDTH-1:0] a_base_s;
    logic                  fwd_a_valid_r;
    logic                  fwd_b_valid_r;
    logic [DATA_WIDTH-1:0] fwd_a_data_r;
    logic [DATA_WIDTH-1:0] fwd_b_data_r;
    logic                  a_hit_s;
    logic                  b_hit_s;
    logic [DATA_WIDTH-1:0] a_value_s;
    logic [DATA_WIDTH-1:0] b_value_s;

    // Next-state logic; the write-snoop window covers the RD_A, RD_B and CAP_B edges.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        window_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = RD_A;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_A: begin
                window_s     = 1'b1;
                state_next_s = RD_B;
            end
            RD_B: begin
                window_s     = 1'b1;
                state_next_s = CAP_B;
            end
            CAP_B: begin
                window_s     = 1'b1;
                state_next_s = HOLD;
            end
            HOLD: begin
                if (bus.op_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Read address and operand-A base: A is taken from rf_q on the RD_B edge,
    // then only patched by forwarding on the CAP_B edge.
    always_comb begin
        rdaddress_s = {ADDR_WIDTH{1'b0}};
        a_base_s    = op_a_r;
        case (state_r)
            RD_A:    rdaddress_s = rs1_r;
            RD_B: begin
                rdaddress_s = rs2_r;
                a_base_s    = bus.rf_q;
            end
            default: rdaddress_s = {ADDR_WIDTH{1'b0}};
        endcase
    end

    rf_operand_fwd #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_fwd_a (
        .addr      (rs1_r),
        .base      (a_base_s),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .fwd_valid (fwd_a_valid_r),
        .fwd_data  (fwd_a_data_r),
        .hit       (a_hit_s),
        .value     (a_value_s)
    );

    rf_operand_fwd #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_fwd_b (
        .addr      (rs2_r),
        .base      (bus.rf_q),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .fwd_valid (fwd_b_valid_r),
        .fwd_data  (fwd_b_data_r),
        .hit       (b_hit_s),
        .value     (b_value_s)
    );

    // Request latch, forwarding flags and operand capture; nothing moves in HOLD.
    always_ff @(posedge clock) begin
        if (reset) begin
            rs1_r         <= {ADDR_WIDTH{1'b0}};
            rs2_r         <= {ADDR_WIDTH{1'b0}};
            fwd_a_valid_r <= 1'b0;
            fwd_b_valid_r <= 1'b0;
            fwd_a_data_r  <= {DATA_WIDTH{1'b0}};
            fwd_b_data_r  <= {DATA_WIDTH{1'b0}};
            op_a_r        <= {DATA_WIDTH{1'b0}};
            op_b_r        <= {DATA_WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                rs1_r         <= bus.req_rs1;
                rs2_r         <= bus.req_rs2;
                fwd_a_valid_r <= 1'b0;
                fwd_b_valid_r <= 1'b0;
                fwd_a_data_r  <= {DATA_WIDTH{1'b0}};
                fwd_b_data_r  <= {DATA_WIDTH{1'b0}};
            end else if (window_s) begin
                if (a_hit_s) begin
                    fwd_a_valid_r <= 1'b1;
                    fwd_a_data_r  <= bus.wr_data;
                end
                if (b_hit_s) begin
                    fwd_b_valid_r <= 1'b1;
                    fwd_b_data_r  <= bus.wr_data;
                end
            end
            if ((state_r == RD_B) || (state_r == CAP_B)) begin
                op_a_r <= a_value_s;
            end
            if (state_r == CAP_B) begin
                op_b_r <= b_value_s;
            end
        end
    end

    assign bus.req_ready    = (state_r == IDLE);
    assign bus.busy         = (state_r != IDLE);
    assign bus.op_valid     = (state_r == HOLD);
    assign bus.rf_rdaddress = rdaddress_s;
    assign bus.op_a         = op_a_r;
    assign bus.op_b         = op_b_r;

endmodule

// File: doc/rf_read_sequencer.md
RF_READ_SEQUENCER -- requirements
Module: rf_read_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 3, register-file address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, register data width.
REQ-003 The block SHALL have port clock  in  1  system clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  in  1  operand-fetch request present.
REQ-006 The block SHALL have port req_ready  out  1  sequencer can accept a request.
REQ-007 The block SHALL have port req_rs1  in  ADDR_WIDTH  source register A.
REQ-008 The block SHALL have port req_rs2  in  ADDR_WIDTH  source register B.
REQ-009 The block SHALL have port rf_rdaddress  out  ADDR_WIDTH  register-file read address; the file samples it each edge and returns data one cycle later, with read-old-value semantics.
REQ-010 The block SHALL have port rf_q  in  DATA_WIDTH  register-file read data.
REQ-011 The block SHALL have port wr_en  in  1  snoop of register-file write enable.
REQ-012 The block SHALL have port wr_addr  in  ADDR_WIDTH  snoop of write address.
REQ-013 The block SHALL have port wr_data  in  DATA_WIDTH  snoop of write data.
REQ-014 The block SHALL have port op_valid  out  1  operands valid.
REQ-015 The block SHALL have port op_ready  in  1  consumer accepts operands.
REQ-016 The block SHALL have port op_a  out  DATA_WIDTH  value of rs1.
REQ-017 The block SHALL have port op_b  out  DATA_WIDTH  value of rs2.
REQ-018 The block SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, RD_A, RD_B, CAP_B and HOLD.
REQ-020 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on an edge where req_valid and req_ready are both 1.
REQ-021 On acceptance, rs1 and rs2 SHALL be latched internally and the FSM SHALL go IDLE->RD_A.
REQ-022 rf_rdaddress SHALL be combinational: latched rs1 in RD_A, latched rs2 in RD_B, 0 otherwise.
REQ-023 The FSM SHALL go RD_A->RD_B unconditionally.
REQ-024 On the RD_B->CAP_B edge, op_a SHALL capture rf_q.
REQ-025 On the CAP_B->HOLD edge, op_b SHALL capture rf_q.
REQ-026 op_valid SHALL be 1 only in HOLD, i.e. exactly 3 cycles after the acceptance edge.
REQ-027 HOLD->IDLE SHALL occur on the edge where op_valid and op_ready are both 1; otherwise the block SHALL stay in HOLD with op_a and op_b stable.
REQ-028 The minimum request-to-request spacing SHALL be 5 cycles with op_ready tied high.
REQ-029 Forwarding: a snooped write (wr_en=1, wr_addr!=0) on any edge from the RD_A->RD_B edge through the CAP_B->HOLD edge SHALL update the operand whose latched address matches wr_addr.
REQ-030 Forwarded data SHALL override the stale rf_q, and the latest matching write SHALL win.
REQ-031 When rs1 == rs2, a matching write SHALL update both operands.
REQ-032 A write on the acceptance edge SHALL need no forwarding, because the register file samples the address afterwards.
REQ-033 Writes after entering HOLD SHALL NOT alter op_a or op_b; the snapshot point is the CAP_B->HOLD edge.
REQ-034 Register 0: an operand whose address is 0 SHALL be delivered as 0 regardless of rf_q or snooped writes.
REQ-035 Writes with wr_addr = 0 SHALL never be forwarded.
REQ-036 A write to an address matching neither operand SHALL have no effect.

Reset
REQ-037 While reset=1 on an edge, the FSM SHALL go to IDLE and op_a, op_b, the latched rs1/rs2 and the forwarding flags SHALL clear to 0, including mid-operation.
REQ-038 After reset, op_valid=0, busy=0, req_ready=1 and rf_rdaddress=0.
REQ-039 Requests presented during reset SHALL NOT be accepted.

Structure
REQ-040 A shared package SHALL hold the FSM state enum (IDLE, RD_A, RD_B, CAP_B, HOLD) and the ZERO_REG=0 constant.
REQ-041 One sub-module, rf_operand_fwd, SHALL perform the per-operand address compare, zero-register masking and forwarding select; it SHALL be instantiated twice.

Verification
REQ-042 Basic fetch: reg3=0x1234, reg5=0xBEEF; request rs1=3, rs2=5 -> op_valid 3 cycles later with op_a=0x1234, op_b=0xBEEF.
REQ-043 Forward miss: request rs1=2, rs2=4; write reg2=0xAAAA on the RD_A->RD_B edge -> op_a=0xAAAA, not the old value.
REQ-044 Double write: rs1=rs2=6; writes 0x1111 then 0x2222 to reg6 on consecutive edges through CAP_B->HOLD -> op_a=op_b=0x2222.
REQ-045 Zero register: rs1=0, rs2=0 with a write of 0xFFFF to address 0 -> op_a=op_b=0.
REQ-046 Backpressure: op_ready=0 for 4 cycles, then a write to rs1 occurs in HOLD -> outputs stable and unchanged; handshake returns to IDLE and req_ready=1 the next cycle.
REQ-047 Reset mid-operation: assert reset in RD_B -> next cycle IDLE, op_valid=0, op_a=op_b=0, busy=0.
